mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in the EX stage alongside the ALU. It accepts `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo` commands from EX, holds the HI/LO register pair, and reports `busy` so the hazard unit can stall dependent `mfhi`/`mflo` and further mult/div instructions. The top-level bench observes it only through the core's register-file and memory traces.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for `mult`/`multu`; legal range 1–15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for `div`/`divu`; legal range 1–15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  command valid this cycle.
- `op`  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6–7 reserved, treated as no-op.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand.
- `busy`  out  1  multi-cycle operation in progress.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- State machine has two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1. It holds a 4-bit down-counter and latched `a`, `b`, and `op`.
- In IDLE, `start`=1 with `op` 0–3:
  - latch operands and op;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- In IDLE, `start`=1 with `op` 4/5: write `a` to HI/LO at that edge and stay IDLE. `busy` never rises.
- In RUN, each edge decrements the counter. On the edge where the counter goes 1→0:
  - HI/LO are written with the result;
  - state returns to IDLE.
- `start` while in RUN is ignored entirely (command dropped; HI/LO untouched). The hazard unit guarantees it never issues one; the bench checks the drop.
- Reserved `op` values with `start`=1: no state change.
- Results are computed from the latched operands. Changes on `a`/`b` during RUN have no effect.
  - mult: signed 64-bit product of a×b; HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
  - divu: unsigned quotient and remainder.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (`b`=0, div or divu): the full DIV_CYCLES busy period still runs, and HI/LO keep their previous values.
- The result may be produced combinationally from the latched operands at the final edge; an iterative datapath is not required.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `reset` low at any time forces the reset values immediately, including mid-RUN. No result is written.
- `start` is accepted at edge T:
  - `busy`=1 from just after T through edge T+N, where N = MULT_CYCLES or DIV_CYCLES;
  - `busy`=0 and new HI/LO are visible just after edge T+N.
- `busy` is therefore high for exactly N cycles.
- A new `start` is accepted at edge T+N+1 at the earliest, because edge T+N still sees RUN. Back-to-back operations have a 1-cycle IDLE gap.
- mthi/mtlo: `hi`/`lo` updated just after the accepting edge, a latency of 1 edge.
- `busy` is a registered output and is not combinational from `start`. The hazard unit stalls on (`start` & op∈0–3) | `busy`.
- HI and LO change only at the completing edge, at the mthi/mtlo edge, or on reset. They are stable throughout RUN.

## Test plan
- Reset, then mult with a=0xFFFFFFFE (−2), b=3 at edge T:
  - `busy` high for 5 cycles;
  - after T+5, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- multu with a=0xFFFFFFFF, b=0xFFFFFFFF: after 5 busy cycles, HI=0xFFFFFFFE and LO=0x00000001.
- div with a=0xFFFFFFF9 (−7), b=2: `busy` 10 cycles, then LO=0xFFFFFFFD (−3) and HI=0xFFFFFFFF (−1).
  - Then divu with the same operands: LO=0x7FFFFFFC and HI=1.
- Edge cases:
  - div by zero after the previous test: 10 busy cycles, HI/LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Interference during RUN and mthi/mtlo:
  - mult in progress; pulse `start` with mthi, a=0x1234 at cycle 2 of RUN. The command is ignored, and the final HI/LO equal the mult result.
  - In IDLE, mthi a=0x1234 and then mtlo a=0x5678: `hi`=0x1234 and `lo`=0x5678 one edge after each, with `busy` never asserting.
- div started, `reset` pulled low mid-RUN: `busy`, `hi` and `lo` go to 0 asynchronously, before the next clock edge.
  - After release, a new mult completes normally in 5 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS
//   core. Owns the HI/LO register pair, executes mult/multu/div/divu over a
//   fixed number of cycles, and applies mthi/mtlo in a single edge.
//
// Parameters
//   MULT_CYCLES  busy length of mult/multu (1..15)
//   DIV_CYCLES   busy length of div/divu   (1..15)
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous reset, active low
//   start  in   1   command valid this cycle
//   op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   a      in  32   rs operand
//   b      in  32   rt operand
//   busy   out  1   multi-cycle operation in progress (registered)
//   hi     out 32   HI register
//   lo     out 32   LO register
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        accept_md;   // mult/div command taken in IDLE
  logic        accept_mthi;
  logic        accept_mtlo;
  logic        done;        // edge where the counter goes 1 -> 0
  logic        div_zero;    // latched div/divu with zero divisor
  logic [63:0] result;      // {HI, LO} computed from latched operands

  // ---------------------------------------------------------------------------
  // Result arithmetic. Signed division is done at 64 bits so that
  // 0x80000000 / 0xFFFFFFFF yields +2^31, whose low word is the required
  // 0x80000000 with remainder 0, without hitting a 32-bit overflow.
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] calc_result(
    input logic [2:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] sy_safe;
    logic        [63:0] ux;
    logic        [63:0] uy;
    logic        [31:0] y_safe;
    logic        [31:0] q;
    logic        [31:0] r;
    logic        [63:0] res;
    sx      = {{32{x[31]}}, x};
    sy      = {{32{y[31]}}, y};
    ux      = {32'b0, x};
    uy      = {32'b0, y};
    // Divide-by-zero results are never written; the guard just keeps the
    // arithmetic well defined.
    sy_safe = (y == 32'b0) ? 64'sd1 : sy;
    y_safe  = (y == 32'b0) ? 32'd1 : y;
    q       = 32'b0;
    r       = 32'b0;
    res     = 64'b0;
    case (o)
      OP_MULT:  res = 64'(sx * sy);
      OP_MULTU: res = ux * uy;
      OP_DIV: begin
        q   = 32'(sx / sy_safe);
        r   = 32'(sx % sy_safe);
        res = {r, q};
      end
      OP_DIVU: begin
        q   = x / y_safe;
        r   = x % y_safe;
        res = {r, q};
      end
      default: res = 64'b0;
    endcase
    return res;
  endfunction

  assign accept_md   = (state_q == IDLE) && start && (op <= OP_DIVU);
  assign accept_mthi = (state_q == IDLE) && start && (op == OP_MTHI);
  assign accept_mtlo = (state_q == IDLE) && start && (op == OP_MTLO);
  assign done        = (state_q == RUN) && (cnt_q <= 4'd1);
  assign div_zero    = ((op_q == OP_DIV) || (op_q == OP_DIVU)) && (b_q == 32'b0);
  assign result      = calc_result(op_q, a_q, b_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_md) state_d = RUN;
      RUN:     if (done)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (busy follows the registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == RUN);
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else if (accept_md) begin
      cnt_q <= (op <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
    end else if (state_q == RUN) begin
      cnt_q <= (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand / op capture (datapath, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept_md) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'b0;
      lo <= 32'b0;
    end else if (done) begin
      if (!div_zero) begin
        hi <= result[63:32];
        lo <= result[31:0];
      end
    end else begin
      if (accept_mthi) hi <= a;
      if (accept_mtlo) lo <= a;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit: directed cases followed by random
//   commands, compared against a behavioural HI/LO model.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Architectural effect of one command on HI/LO, from the instruction rules.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    case (o)
      3'd0: begin sp = sx * sy; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
      3'd1: begin up = ux * uy; exp_hi = up[63:32]; exp_lo = up[31:0]; end
      3'd2: if (y != 0) begin
        sq = sx / sy; sr = sx % sy;
        exp_lo = sq[31:0]; exp_hi = sr[31:0];
      end
      3'd3: if (y != 0) begin
        exp_lo = x / y; exp_hi = x % y;
      end
      3'd4: exp_hi = x;
      3'd5: exp_lo = x;
      default: ;
    endcase
  endtask

  function automatic int busy_len(input logic [2:0] o);
    if (o <= 3'd1) return MULT_N;
    if (o <= 3'd3) return DIV_N;
    return 0;
  endfunction

  // Issue one command, scramble a/b during RUN, optionally inject an mthi
  // during RUN, then check busy length, HI/LO stability and final values.
  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input bit inject);
    logic [31:0] hi0, lo0;
    int          cnt;
    bit          stable;
    hi0 = exp_hi;
    lo0 = exp_lo;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    model(o, x, y);
    cnt    = 0;
    stable = 1'b1;
    while (busy && cnt < 40) begin
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      if (inject && cnt == 1) begin
        start = 1'b1; op = 3'd4; a = 32'h1234;
      end else begin
        start = 1'b0;
      end
      cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " busy cycles"}, 64'(cnt), 64'(busy_len(o)));
    if (busy_len(o) > 0) chk({tag, " stable in RUN"}, 64'(stable), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_hi = 32'b0;
    exp_lo = 32'b0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    a      = 32'b0;
    b      = 32'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hi",   64'(hi),   64'd0);
    chk("reset lo",   64'(lo),   64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    do_op("mult -2*3",   3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult -2*3 golden hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult -2*3 golden lo", 64'(lo), 64'hFFFF_FFFA);
    do_op("multu max",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu golden hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu golden lo", 64'(lo), 64'h0000_0001);
    do_op("div -7/2",    3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div golden lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div golden hi", 64'(hi), 64'hFFFF_FFFF);
    do_op("divu -7/2",   3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("divu golden lo", 64'(lo), 64'h7FFF_FFFC);
    chk("divu golden hi", 64'(hi), 64'h0000_0001);
    do_op("div by 0",    3'd2, 32'h1234_5678, 32'd0, 1'b0);
    chk("div0 keeps lo", 64'(lo), 64'h7FFF_FFFC);
    do_op("divu by 0",   3'd3, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_op("div ovf",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div ovf golden lo", 64'(lo), 64'h8000_0000);
    chk("div ovf golden hi", 64'(hi), 64'h0);
    do_op("mult w/ mthi", 3'd0, 32'h0001_0003, 32'hFFFF_0007, 1'b1);
    do_op("mthi",        3'd4, 32'h0000_1234, 32'd0, 1'b0);
    do_op("mtlo",        3'd5, 32'h0000_5678, 32'd0, 1'b0);
    chk("mthi golden", 64'(hi), 64'h1234);
    chk("mtlo golden", 64'(lo), 64'h5678);
    do_op("reserved 6",  3'd6, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    do_op("reserved 7",  3'd7, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst hi",   64'(hi),   64'd0);
    chk("async rst lo",   64'(lo),   64'd0);
    exp_hi = 32'b0;
    exp_lo = 32'b0;
    @(negedge clk);
    reset = 1'b1;
    do_op("mult after rst", 3'd0, 32'd12345, 32'hFFFF_FF00, 1'b0);

    // Random commands
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
